// File: rtl/plc_scan_ctrl_pkg.sv
// Shared definitions for the PLC scan-cycle sequencer: state encodings and
// default timing parameters.
package plc_scan_ctrl_pkg;

  localparam int unsigned PHASE_BITS    = 3;
  localparam int unsigned DEF_WDT_LIMIT = 1000;
  localparam int unsigned DEF_MIN_SCAN  = 0;

  typedef enum logic [PHASE_BITS-1:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    EXEC   = 3'd2,
    COMMIT = 3'd3,
    WAIT   = 3'd4,
    FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/plc_scan_ctrl_if.sv
// CPU-facing side of the scan controller: I/O images, END pulse and CPU
// reset/run controls.
interface plc_scan_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] in_image;
  logic [WIDTH-1:0] out_shadow;
  logic             scan_end;
  logic             cpu_rst;
  logic             cpu_run;

  modport master (
    output in_image,
    output cpu_rst,
    output cpu_run,
    input  out_shadow,
    input  scan_end
  );

  modport slave (
    input  in_image,
    input  cpu_rst,
    input  cpu_run,
    output out_shadow,
    output scan_end
  );
endinterface

// File: rtl/plc_scan_ctrl_wdt_timer.sv
// Clear/enable counter that saturates at all-ones, with a terminal-count
// flag raised once the count reaches the supplied limit.
module wdt_timer #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [BITS-1:0] limit,
  output logic            tc
);
  logic [BITS-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + BITS'(1);
    end
  end

  assign tc = (count >= limit);
endmodule

// File: rtl/plc_scan_ctrl.sv
// Scan-cycle sequencer: freezes inputs, runs the CPU until END or watchdog
// expiry, commits outputs, and optionally pads the scan to a minimum period.
module plc_scan_ctrl
  import plc_scan_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned WDT_BITS  = 16,
  parameter int unsigned WDT_LIMIT = DEF_WDT_LIMIT,
  parameter int unsigned MIN_SCAN  = DEF_MIN_SCAN
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic                  fault_clr,
  input  logic [WIDTH-1:0]      in_pins,
  output logic [WIDTH-1:0]      out_pins,
  output logic                  wdt_fault,
  output logic [15:0]           scan_count,
  output logic [PHASE_BITS-1:0] phase,
  plc_scan_ctrl_if.master       cpu
);
  localparam logic [WDT_BITS-1:0] WDT_TC = WDT_BITS'(WDT_LIMIT - 1);
  // Exit test is made on the timer value before this cycle's increment,
  // so comparing against MIN_SCAN-2 yields a period of exactly MIN_SCAN.
  localparam logic [WDT_BITS-1:0] SCAN_TC =
    (MIN_SCAN >= 2) ? WDT_BITS'(MIN_SCAN - 2) : '0;

  state_t state, state_nxt;
  logic   wdt_clr, wdt_en, wdt_tc;
  logic   scan_clr, scan_en, scan_tc;

  wdt_timer #(.BITS(WDT_BITS)) u_wdt (
    .clk   (clk_in),
    .rst   (rst_in),
    .clr   (wdt_clr),
    .en    (wdt_en),
    .limit (WDT_TC),
    .tc    (wdt_tc)
  );

  wdt_timer #(.BITS(WDT_BITS)) u_scan (
    .clk   (clk_in),
    .rst   (rst_in),
    .clr   (scan_clr),
    .en    (scan_en),
    .limit (SCAN_TC),
    .tc    (scan_tc)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wdt_clr   = 1'b0;
    wdt_en    = 1'b0;
    scan_clr  = 1'b0;
    scan_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        wdt_clr   = 1'b1;
        scan_clr  = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        wdt_en  = 1'b1;
        scan_en = 1'b1;
        if (cpu.scan_end)  state_nxt = COMMIT;
        else if (wdt_tc)   state_nxt = FAULT;
      end
      COMMIT, WAIT: begin
        scan_en = 1'b1;
        if (scan_tc) state_nxt = start ? SAMPLE : IDLE;
        else         state_nxt = WAIT;
      end
      FAULT: begin
        if (fault_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu.in_image <= '0;
      out_pins     <= '0;
      scan_count   <= '0;
    end else begin
      if (state == SAMPLE) cpu.in_image <= in_pins;
      if (state == COMMIT) begin
        out_pins   <= cpu.out_shadow;
        scan_count <= scan_count + 16'd1;
      end
      if ((state == EXEC) && (state_nxt == FAULT)) out_pins <= '0;
    end
  end

  assign cpu.cpu_rst = (state != EXEC);
  assign cpu.cpu_run = (state == EXEC);
  assign wdt_fault   = (state == FAULT);
  assign phase       = state;
endmodule

// File: tb/tb_plc_scan_ctrl.sv
// Directed bench for plc_scan_ctrl: vector table for reset, scan, watchdog and
// reset-mid-scan; hand sequences for the minimum-period instance.
module tb_plc_scan_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Instance A: short watchdog, free-running scan
  logic        a_rst, a_start, a_fclr;
  logic [15:0] a_pins, a_out, a_cnt;
  logic        a_fault;
  logic [2:0]  a_phase;
  plc_scan_ctrl_if #(.WIDTH(16)) if_a ();

  plc_scan_ctrl #(.WIDTH(16), .WDT_BITS(16), .WDT_LIMIT(8), .MIN_SCAN(0)) dut_a (
    .clk_in     (clk),
    .rst_in     (a_rst),
    .start      (a_start),
    .fault_clr  (a_fclr),
    .in_pins    (a_pins),
    .out_pins   (a_out),
    .wdt_fault  (a_fault),
    .scan_count (a_cnt),
    .phase      (a_phase),
    .cpu        (if_a)
  );

  // Instance B: fixed 20-cycle minimum scan period
  logic        b_rst, b_start, b_fclr;
  logic [15:0] b_pins, b_out, b_cnt;
  logic        b_fault;
  logic [2:0]  b_phase;
  plc_scan_ctrl_if #(.WIDTH(16)) if_b ();

  plc_scan_ctrl #(.WIDTH(16), .WDT_BITS(16), .WDT_LIMIT(8), .MIN_SCAN(20)) dut_b (
    .clk_in     (clk),
    .rst_in     (b_rst),
    .start      (b_start),
    .fault_clr  (b_fclr),
    .in_pins    (b_pins),
    .out_pins   (b_out),
    .wdt_fault  (b_fault),
    .scan_count (b_cnt),
    .phase      (b_phase),
    .cpu        (if_b)
  );

  typedef struct {
    logic        rst, start, se, fc;
    logic [15:0] pins, shadow;
    logic [2:0]  ph;
    logic [15:0] img, outp, cnt;
  } vec_t;

  vec_t vecs[$];
  int   cyc;

  task automatic add(input logic rst, start, se, fc, input logic [15:0] pins, shadow,
                     input logic [2:0] ph, input logic [15:0] img, outp, cnt);
    vec_t v;
    v.rst = rst; v.start = start; v.se = se; v.fc = fc;
    v.pins = pins; v.shadow = shadow;
    v.ph = ph; v.img = img; v.outp = outp; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nwait;
    a_rst = 1'b1; a_start = 1'b0; a_fclr = 1'b0; a_pins = '0;
    if_a.scan_end = 1'b0; if_a.out_shadow = '0;
    b_rst = 1'b1; b_start = 1'b0; b_fclr = 1'b0; b_pins = '0;
    if_b.scan_end = 1'b0; if_b.out_shadow = '0;

    //   rst start se fc pins      shadow     ph  img        out        cnt
    add(1, 1, 0, 0, 16'hA5A5, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    add(1, 1, 0, 0, 16'hA5A5, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    add(0, 1, 0, 0, 16'hA5A5, 16'h0000, 1, 16'h0000, 16'h0000, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 0, 16'hA5A5, 16'h1234, 2, 16'hA5A5, 16'h0000, 0);
    add(0, 1, 1, 0, 16'hA5A5, 16'h1234, 3, 16'hA5A5, 16'h0000, 0);
    add(0, 1, 0, 0, 16'h5A5A, 16'h1234, 1, 16'hA5A5, 16'h1234, 1);
    add(0, 1, 0, 0, 16'h5A5A, 16'hFFFF, 2, 16'h5A5A, 16'h1234, 1);
    add(0, 1, 1, 0, 16'h5A5A, 16'hFFFF, 3, 16'h5A5A, 16'h1234, 1);
    add(0, 1, 0, 0, 16'h5A5A, 16'hFFFF, 1, 16'h5A5A, 16'hFFFF, 2);
    // scan_end during SAMPLE must not skip EXEC
    add(0, 1, 1, 0, 16'h5A5A, 16'hFFFF, 2, 16'h5A5A, 16'hFFFF, 2);
    for (int i = 0; i < 7; i++)
      add(0, 1, 0, 0, 16'h5A5A, 16'hFFFF, 2, 16'h5A5A, 16'hFFFF, 2);
    add(0, 1, 0, 0, 16'h5A5A, 16'hFFFF, 5, 16'h5A5A, 16'h0000, 2);
    add(0, 1, 0, 0, 16'h5A5A, 16'hFFFF, 5, 16'h5A5A, 16'h0000, 2);
    add(0, 0, 0, 1, 16'h5A5A, 16'hFFFF, 0, 16'h5A5A, 16'h0000, 2);
    add(0, 0, 0, 0, 16'h5A5A, 16'hFFFF, 0, 16'h5A5A, 16'h0000, 2);
    // scan_end on the 8th EXEC cycle beats the watchdog
    add(0, 1, 0, 0, 16'h0F0F, 16'hC3C3, 1, 16'h5A5A, 16'h0000, 2);
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 0, 16'h0F0F, 16'hC3C3, 2, 16'h0F0F, 16'h0000, 2);
    add(0, 1, 1, 0, 16'h0F0F, 16'hC3C3, 3, 16'h0F0F, 16'h0000, 2);
    add(0, 0, 0, 0, 16'h0F0F, 16'hC3C3, 0, 16'h0F0F, 16'hC3C3, 3);
    // reset asserted during the second EXEC cycle
    add(0, 1, 0, 0, 16'h1111, 16'hC3C3, 1, 16'h0F0F, 16'hC3C3, 3);
    add(0, 1, 0, 0, 16'h1111, 16'hC3C3, 2, 16'h1111, 16'hC3C3, 3);
    add(0, 1, 0, 0, 16'h1111, 16'hC3C3, 2, 16'h1111, 16'hC3C3, 3);
    add(1, 1, 0, 0, 16'h1111, 16'hC3C3, 0, 16'h0000, 16'h0000, 0);
    add(0, 0, 0, 0, 16'h1111, 16'hC3C3, 0, 16'h0000, 16'h0000, 0);

    foreach (vecs[i]) begin
      a_rst = vecs[i].rst; a_start = vecs[i].start; a_fclr = vecs[i].fc;
      a_pins = vecs[i].pins; if_a.scan_end = vecs[i].se; if_a.out_shadow = vecs[i].shadow;
      tick();
      check($sformatf("v%0d phase", i),     32'(a_phase), 32'(vecs[i].ph));
      check($sformatf("v%0d cpu_run", i),   32'(if_a.cpu_run), 32'(vecs[i].ph == 3'd2));
      check($sformatf("v%0d cpu_rst", i),   32'(if_a.cpu_rst), 32'(vecs[i].ph != 3'd2));
      check($sformatf("v%0d wdt_fault", i), 32'(a_fault), 32'(vecs[i].ph == 3'd5));
      check($sformatf("v%0d out_pins", i),  32'(a_out), 32'(vecs[i].outp));
      check($sformatf("v%0d in_image", i),  32'(if_a.in_image), 32'(vecs[i].img));
      check($sformatf("v%0d scan_count", i), 32'(a_cnt), 32'(vecs[i].cnt));
    end
    a_start = 1'b0; a_rst = 1'b0; if_a.scan_end = 1'b0;

    // Minimum period, E=3: 15 WAIT cycles, SAMPLE-to-SAMPLE 20
    b_rst = 1'b1; tick(); tick(); b_rst = 1'b0;
    check("b_reset_phase", 32'(b_phase), 32'd0);
    b_start = 1'b1; b_pins = 16'h00FF;
    tick(); cyc = 0;
    check("b_sample1", 32'(b_phase), 32'd1);
    tick(); tick(); tick();
    check("b_exec_c3", 32'(b_phase), 32'd2);
    if_b.scan_end = 1'b1; if_b.out_shadow = 16'h0BAD;
    tick(); if_b.scan_end = 1'b0;
    check("b_commit1", 32'(b_phase), 32'd3);
    nwait = 0;
    tick();
    while (b_phase == 3'd4 && nwait < 40) begin
      nwait++;
      tick();
    end
    check("b_wait_cycles1", 32'(nwait), 32'd15);
    check("b_resample_phase", 32'(b_phase), 32'd1);
    check("b_period", 32'(cyc), 32'd20);
    check("b_out_pins1", 32'(b_out), 32'h0BAD);
    check("b_count1", 32'(b_cnt), 32'd1);
    check("b_in_image", 32'(if_b.in_image), 32'h00FF);

    // start dropped mid-scan: scan finishes, pads, then IDLE
    tick();
    b_start = 1'b0;
    tick(); tick();
    if_b.scan_end = 1'b1; if_b.out_shadow = 16'h7777;
    tick(); if_b.scan_end = 1'b0;
    check("b_commit2", 32'(b_phase), 32'd3);
    nwait = 0;
    tick();
    while (b_phase == 3'd4 && nwait < 40) begin
      nwait++;
      tick();
    end
    check("b_wait_cycles2", 32'(nwait), 32'd15);
    check("b_idle_after_stop", 32'(b_phase), 32'd0);
    check("b_out_pins2", 32'(b_out), 32'h7777);
    check("b_count2", 32'(b_cnt), 32'd2);
    tick();
    check("b_idle_hold", 32'(b_phase), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
